// File: rtl/nvme_admin_ctrl.sv
// nvme_admin_ctrl: NVMe controller endpoint for the admin SQ/CQ pair only.
// Register requests arrive as 64-bit PCIe words. Each submitted command is
// fetched, moved with one 4 KiB DMA, completed into the CQ and signalled by MSI.
// Optional build macro NVME_STATS_EN enables the statistics counters; without
// it the counters read as zero.
module nvme_admin_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int MAX_QUEUES     = 64,
    parameter int QUEUE_DEPTH    = 1024,
    parameter int MAX_NAMESPACES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           pcie_rx_data,
    input  logic                  pcie_rx_valid,
    output logic                  pcie_rx_ready,
    output logic [63:0]           pcie_tx_data,
    output logic                  pcie_tx_valid,
    input  logic                  pcie_tx_ready,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_write,
    output logic [7:0]            mem_size,
    input  logic                  mem_ready,
    input  logic                  mem_valid,
    output logic                  dma_req,
    input  logic                  dma_ack,
    output logic [ADDR_WIDTH-1:0] dma_src_addr,
    output logic [ADDR_WIDTH-1:0] dma_dst_addr,
    output logic [31:0]           dma_length,
    output logic                  dma_write,
    input  logic                  dma_done,
    input  logic                  dma_error,
    output logic [15:0]           msi_vector,
    output logic                  msi_valid,
    input  logic                  msi_ready,
    output logic                  controller_ready,
    output logic [15:0]           active_queues,
    output logic [31:0]           commands_processed,
    output logic [31:0]           error_count,
    output logic [63:0]           data_transferred
);

    typedef enum logic [2:0] {
        S_DISABLED, S_ENABLING, S_READY, S_FETCH,
        S_DMA_REQ, S_DMA_WAIT, S_CQ_WRITE, S_MSI
    } state_t;

    state_t      state, state_next;
    logic [3:0]  en_cnt;
    logic        cc_en;
    logic [11:0] asq_sz_m1, acq_sz_m1;
    logic [31:0] asq_lo, asq_hi, acq_lo, acq_hi;
    logic [15:0] sq_head, sq_tail, cq_tail, sq_size, cq_size;
    logic        phase;
    logic        cmd_dir;
    logic [15:0] cmd_cid;
    logic [31:0] cmd_prp;
    logic [15:0] status;
    logic [31:0] rd_data;
    logic        req_fire, wr_fire, rd_flag;
    logic [30:0] reg_addr;
    logic [31:0] wr_data;
    logic        unused_cmd_bits;

    // Queue size from an AQA "size minus one" field, clamped to the supported depth.
    function automatic logic [15:0] queue_size(input logic [11:0] size_m1);
        if (int'(size_m1) >= QUEUE_DEPTH - 1) return 16'(QUEUE_DEPTH);
        return {4'h0, size_m1} + 16'd1;
    endfunction

    // Advance a ring pointer, wrapping at the queue size.
    function automatic logic [15:0] ring_inc(input logic [15:0] ptr, input logic [15:0] size);
        if (ptr + 16'd1 >= size) return 16'd0;
        return ptr + 16'd1;
    endfunction

    assign rd_flag         = pcie_rx_data[63];
    assign reg_addr        = pcie_rx_data[62:32];
    assign wr_data         = pcie_rx_data[31:0];
    assign pcie_rx_ready   = !rst && !pcie_tx_valid;
    assign req_fire        = pcie_rx_valid && pcie_rx_ready;
    assign wr_fire         = req_fire && !rd_flag;
    assign sq_size         = queue_size(asq_sz_m1);
    assign cq_size         = queue_size(acq_sz_m1);
    assign controller_ready = (state != S_DISABLED) && (state != S_ENABLING);
    assign active_queues   = {15'h0, controller_ready};
    assign msi_vector      = 16'h0;
    // Opcode bits above the direction bit and the reserved byte are not used.
    assign unused_cmd_bits = ^mem_rdata[15:1];

    // Register read multiplexer.
    always_comb begin
        rd_data = 32'h0;
        case (reg_addr)
            31'h00:   rd_data = {16'(MAX_QUEUES - 1), 16'(QUEUE_DEPTH - 1)};
            31'h08:   rd_data = 32'h0001_0400;
            31'h14:   rd_data = {31'h0, cc_en};
            31'h1C:   rd_data = {31'h0, controller_ready};
            31'h24:   rd_data = {4'h0, acq_sz_m1, 4'h0, asq_sz_m1};
            31'h28:   rd_data = asq_lo;
            31'h2C:   rd_data = asq_hi;
            31'h30:   rd_data = acq_lo;
            31'h34:   rd_data = acq_hi;
            31'h38:   rd_data = 32'(MAX_NAMESPACES);
            31'h1000: rd_data = {16'h0, sq_tail};
            default:  rd_data = 32'h0;
        endcase
    end

    // Read response register: held until the host side accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcie_tx_valid <= 1'b0;
            pcie_tx_data  <= 64'h0;
        end else if (req_fire && rd_flag) begin
            pcie_tx_valid <= 1'b1;
            pcie_tx_data  <= {1'b0, reg_addr, rd_data};
        end else if (pcie_tx_valid && pcie_tx_ready) begin
            pcie_tx_valid <= 1'b0;
        end
    end

    // Host-programmed configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_en     <= 1'b0;
            asq_sz_m1 <= 12'h0;
            acq_sz_m1 <= 12'h0;
            asq_lo    <= 32'h0;
            asq_hi    <= 32'h0;
            acq_lo    <= 32'h0;
            acq_hi    <= 32'h0;
        end else if (wr_fire) begin
            case (reg_addr)
                31'h14: cc_en <= wr_data[0];
                31'h24: begin
                    asq_sz_m1 <= wr_data[11:0];
                    acq_sz_m1 <= wr_data[27:16];
                end
                31'h28: asq_lo <= wr_data;
                31'h2C: asq_hi <= wr_data;
                31'h30: acq_lo <= wr_data;
                31'h34: acq_hi <= wr_data;
                default: ;
            endcase
        end
    end

    // Queue pointers; cleared while the controller is disabled. The CQ phase
    // tag restarts at 1 so the host can tell fresh entries from zeroed memory.
    always_ff @(posedge clk) begin
        if (rst || !cc_en) begin
            sq_head <= 16'h0;
            sq_tail <= 16'h0;
            cq_tail <= 16'h0;
            phase   <= 1'b1;
        end else begin
            if (wr_fire && reg_addr == 31'h1000 && wr_data < {16'h0, sq_size})
                sq_tail <= wr_data[15:0];
            if (state == S_FETCH && mem_valid)
                sq_head <= ring_inc(sq_head, sq_size);
            if (state == S_CQ_WRITE && mem_ready) begin
                cq_tail <= ring_inc(cq_tail, cq_size);
                if (cq_tail + 16'd1 >= cq_size) phase <= ~phase;
            end
        end
    end

    // Decoded command fields and the completion status of the current command.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_dir <= 1'b0;
            cmd_cid <= 16'h0;
            cmd_prp <= 32'h0;
            status  <= 16'h0;
        end else begin
            if (state == S_FETCH && mem_valid) begin
                cmd_dir <= mem_rdata[0];
                cmd_cid <= mem_rdata[31:16];
                cmd_prp <= mem_rdata[63:32];
            end
            if (state == S_DMA_WAIT && (dma_done || dma_error))
                status <= dma_error ? 16'h0004 : 16'h0000;
        end
    end

    // State register and enable-delay counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_DISABLED;
            en_cnt <= 4'h0;
        end else begin
            state  <= state_next;
            en_cnt <= (state == S_ENABLING) ? en_cnt + 4'd1 : 4'h0;
        end
    end

    // Next-state and per-state memory/DMA/MSI request outputs.
    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 8'h0;
        mem_addr     = '0;
        mem_wdata    = '0;
        dma_req      = 1'b0;
        dma_src_addr = '0;
        dma_dst_addr = '0;
        dma_length   = 32'h0;
        dma_write    = 1'b0;
        msi_valid    = 1'b0;
        case (state)
            S_DISABLED: state_next = S_ENABLING;
            S_ENABLING: if (en_cnt == 4'd15) state_next = S_READY;
            S_READY:    if (sq_head != sq_tail) state_next = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_size = 8'd64;
                mem_addr = ADDR_WIDTH'({asq_hi, asq_lo} + {42'h0, sq_head, 6'h0});
                if (mem_valid) state_next = S_DMA_REQ;
            end
            S_DMA_REQ: begin
                dma_req      = 1'b1;
                dma_src_addr = ADDR_WIDTH'({20'h0, cmd_prp, 12'h0});
                dma_length   = 32'd4096;
                dma_write    = cmd_dir;
                if (dma_ack) state_next = S_DMA_WAIT;
            end
            S_DMA_WAIT: if (dma_done || dma_error) state_next = S_CQ_WRITE;
            S_CQ_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                mem_size  = 8'd16;
                mem_addr  = ADDR_WIDTH'({acq_hi, acq_lo} + {44'h0, cq_tail, 4'h0});
                mem_wdata = {status[15:1], phase, cmd_cid, 16'h0, sq_head};
                if (mem_ready) state_next = S_MSI;
            end
            S_MSI: begin
                msi_valid = 1'b1;
                if (msi_ready) state_next = S_READY;
            end
            default: state_next = S_DISABLED;
        endcase
        if (!cc_en) state_next = S_DISABLED;
    end

`ifdef NVME_STATS_EN
    // Statistics: completions, DMA error cycles and successfully moved bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            commands_processed <= 32'h0;
            error_count        <= 32'h0;
            data_transferred   <= 64'h0;
        end else begin
            if (msi_valid && msi_ready) commands_processed <= commands_processed + 32'd1;
            if (dma_error)              error_count <= error_count + 32'd1;
            if (dma_done && !dma_error) data_transferred <= data_transferred + 64'd4096;
        end
    end
`else
    assign commands_processed = 32'h0;
    assign error_count        = 32'h0;
    assign data_transferred   = 64'h0;
`endif

endmodule

// File: tb/tb_nvme_admin_ctrl.sv
// tb_nvme_admin_ctrl: bench for nvme_admin_ctrl acting as host, memory and DMA engine.
module tb_nvme_admin_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pcie_rx_data = '0;
    logic        pcie_rx_valid = 1'b0, pcie_rx_ready;
    logic [63:0] pcie_tx_data;
    logic        pcie_tx_valid, pcie_tx_ready = 1'b0;
    logic        mem_req, mem_write, mem_ready = 1'b0, mem_valid = 1'b0;
    logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [7:0]  mem_size;
    logic        dma_req, dma_ack = 1'b0, dma_write, dma_done = 1'b0, dma_error = 1'b0;
    logic [63:0] dma_src_addr, dma_dst_addr;
    logic [31:0] dma_length;
    logic [15:0] msi_vector, active_queues;
    logic        msi_valid, msi_ready = 1'b0, controller_ready;
    logic [31:0] commands_processed, error_count;
    logic [63:0] data_transferred;

    int checks = 0;
    int errors = 0;

`ifdef NVME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Reference model of host-visible controller state.
    int unsigned     m_sq_size, m_cq_size, m_head, m_tail, m_cq_tail;
    bit              m_phase;
    longint unsigned m_asq, m_acq, m_bytes;
    int unsigned     m_cmds, m_errs;

    typedef struct packed {
        logic        ok;
        logic [63:0] fetch_addr;
        logic [7:0]  fetch_size;
        logic        fetch_wr;
        logic [63:0] dma_src;
        logic [63:0] dma_dst;
        logic [31:0] dma_len;
        logic        dma_wr;
        logic        ack_drop;
        logic [63:0] cq_addr;
        logic [63:0] cq_data;
        logic [7:0]  cq_size;
        logic        cq_wr;
        logic [15:0] msi_vec;
    } obs_t;

    nvme_admin_ctrl dut (
        .clk(clk), .rst(rst),
        .pcie_rx_data(pcie_rx_data), .pcie_rx_valid(pcie_rx_valid), .pcie_rx_ready(pcie_rx_ready),
        .pcie_tx_data(pcie_tx_data), .pcie_tx_valid(pcie_tx_valid), .pcie_tx_ready(pcie_tx_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_write(mem_write), .mem_size(mem_size), .mem_ready(mem_ready), .mem_valid(mem_valid),
        .dma_req(dma_req), .dma_ack(dma_ack), .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr),
        .dma_length(dma_length), .dma_write(dma_write), .dma_done(dma_done), .dma_error(dma_error),
        .msi_vector(msi_vector), .msi_valid(msi_valid), .msi_ready(msi_ready),
        .controller_ready(controller_ready), .active_queues(active_queues),
        .commands_processed(commands_processed), .error_count(error_count),
        .data_transferred(data_transferred)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [30:0] a, input logic [31:0] d);
        int n = 0;
        pcie_rx_data  = {1'b0, a, d};
        pcie_rx_valid = 1'b1;
        while (!pcie_rx_ready && n < 50) begin step(); n++; end
        if (!pcie_rx_ready) begin
            errors++;
            $display("FAIL reg_write_accept: addr %h not accepted, required accept within 50 cycles", a);
        end
        step();
        pcie_rx_valid = 1'b0;
    endtask

    task automatic reg_read(input logic [30:0] a, output logic [63:0] d, output bit ok);
        int n = 0;
        pcie_rx_data  = {1'b1, a, 32'h0};
        pcie_rx_valid = 1'b1;
        while (!pcie_rx_ready && n < 50) begin step(); n++; end
        step();
        pcie_rx_valid = 1'b0;
        n = 0;
        while (!pcie_tx_valid && n < 20) begin step(); n++; end
        ok = pcie_tx_valid;
        d  = pcie_tx_data;
        pcie_tx_ready = 1'b1;
        step();
        pcie_tx_ready = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!controller_ready && cycles < 20) begin step(); cycles++; end
    endtask

    // Plays memory and DMA engine for one command. mode: 0 done, 1 error, 2 done+error.
    // db >= 0 rings the doorbell with that value while the DMA is in flight.
    task automatic run_cmd(input logic [63:0] cmd, input int mode, input int db, output obs_t o);
        int n, gap;
        o = '0;
        o.ok = 1'b1;
        n = 0;
        while (!mem_req && n < 100) begin step(); n++; end
        if (!mem_req) o.ok = 1'b0;
        o.fetch_addr = mem_addr; o.fetch_size = mem_size; o.fetch_wr = mem_write;
        mem_rdata = cmd; mem_valid = 1'b1;
        step();
        mem_valid = 1'b0; mem_rdata = {$urandom, $urandom};
        n = 0;
        while (!dma_req && n < 100) begin step(); n++; end
        if (!dma_req) o.ok = 1'b0;
        o.dma_src = dma_src_addr; o.dma_dst = dma_dst_addr; o.dma_len = dma_length; o.dma_wr = dma_write;
        dma_ack = 1'b1;
        step();
        dma_ack = 1'b0;
        o.ack_drop = !dma_req;
        if (db >= 0) reg_write(31'h1000, db);
        gap = int'($urandom_range(0, 3));
        for (int k = 0; k < gap; k++) step();
        dma_done  = (mode != 1);
        dma_error = (mode != 0);
        step();
        dma_done = 1'b0; dma_error = 1'b0;
        n = 0;
        while (!mem_req && n < 100) begin step(); n++; end
        if (!mem_req) o.ok = 1'b0;
        o.cq_addr = mem_addr; o.cq_data = mem_wdata; o.cq_size = mem_size; o.cq_wr = mem_write;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        n = 0;
        while (!msi_valid && n < 100) begin step(); n++; end
        if (!msi_valid) o.ok = 1'b0;
        o.msi_vec = msi_vector;
        msi_ready = 1'b1;
        step();
        msi_ready = 1'b0;
    endtask

    // Expected traffic for the next command according to the queue rules.
    task automatic model_cmd(input logic [63:0] cmd, input int mode,
                             output logic [63:0] e_fetch, output logic [63:0] e_src,
                             output logic [63:0] e_cq_addr, output logic [63:0] e_cq_data);
        logic [15:0] st;
        logic [15:0] cid;
        e_fetch = m_asq + 64'(m_head) * 64;
        m_head  = (m_head + 1) % m_sq_size;
        e_src   = 64'(cmd[63:32]) * 4096;
        st      = (mode != 0) ? 16'h0004 : 16'h0000;
        cid     = cmd[31:16];
        e_cq_addr = m_acq + 64'(m_cq_tail) * 16;
        e_cq_data = {st[15:1], m_phase, cid, 16'h0, 16'(m_head)};
        m_cq_tail = m_cq_tail + 1;
        if (m_cq_tail == m_cq_size) begin m_cq_tail = 0; m_phase = !m_phase; end
        m_cmds++;
        if (mode != 0) m_errs++;
        else m_bytes += 4096;
    endtask

    task automatic test_reset();
        logic [599:0] outs;
        rst = 1'b1;
        step(); step();
        checks++;
        if (pcie_rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b required 0", pcie_rx_ready); end
        outs = 600'({pcie_tx_valid, pcie_tx_data, mem_req, mem_addr, mem_wdata, mem_write, mem_size,
                     dma_req, dma_src_addr, dma_dst_addr, dma_length, dma_write, msi_vector, msi_valid,
                     controller_ready, active_queues, commands_processed, error_count, data_transferred});
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
        rst = 1'b0;
        #1;
        checks++;
        if (pcie_rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after_reset: got %b required 1", pcie_rx_ready); end
        step();
        checks++;
        if ({controller_ready, active_queues} !== 17'h0) begin
            errors++; $display("FAIL idle_status: ready %b queues %0d required 0/0", controller_ready, active_queues);
        end
        m_head = 0; m_tail = 0; m_cq_tail = 0; m_phase = 1'b1;
        m_cmds = 0; m_errs = 0; m_bytes = 0;
    endtask

    task automatic test_registers();
        logic [63:0] d;
        bit ok;
        int n = 0;
        pcie_rx_data = {1'b1, 31'h08, 32'h0};
        pcie_rx_valid = 1'b1;
        step();
        pcie_rx_valid = 1'b0;
        while (!pcie_tx_valid && n < 5) begin step(); n++; end
        checks++;
        if (pcie_tx_valid !== 1'b1 || pcie_tx_data !== 64'h00000008_00010400) begin
            errors++; $display("FAIL vs_read: got valid %b data %h required 1 0000000800010400", pcie_tx_valid, pcie_tx_data);
        end
        for (int k = 0; k < 3; k++) step();
        checks++;
        if ({pcie_tx_valid, pcie_rx_ready} !== 2'b10 || pcie_tx_data !== 64'h00000008_00010400) begin
            errors++; $display("FAIL tx_hold: got valid %b rx_ready %b data %h required 1 0 0000000800010400",
                               pcie_tx_valid, pcie_rx_ready, pcie_tx_data);
        end
        pcie_tx_ready = 1'b1;
        step();
        pcie_tx_ready = 1'b0;
        checks++;
        if ({pcie_tx_valid, pcie_rx_ready} !== 2'b01) begin
            errors++; $display("FAIL tx_release: got valid %b rx_ready %b required 0 1", pcie_tx_valid, pcie_rx_ready);
        end
        reg_write(31'h00, 32'hFFFF_FFFF);
        reg_read(31'h00, d, ok);
        checks++;
        if (!ok || d !== {32'h0, 16'(64 - 1), 16'(1024 - 1)}) begin
            errors++; $display("FAIL cap_read: got %h required %h", d, {32'h0, 16'(63), 16'(1023)});
        end
        reg_read(31'h38, d, ok);
        checks++;
        if (!ok || d !== 64'h00000038_00000010) begin errors++; $display("FAIL ns_read: got %h required 0000003800000010", d); end
        reg_write(31'h40, 32'h1234_5678);
        reg_read(31'h40, d, ok);
        checks++;
        if (!ok || d !== 64'h00000040_00000000) begin errors++; $display("FAIL unmapped_read: got %h required 0000004000000000", d); end
    endtask

    task automatic test_enable();
        int cyc;
        logic [63:0] d;
        bit ok;
        reg_write(31'h14, 32'h1);
        checks++;
        if (controller_ready !== 1'b0) begin errors++; $display("FAIL enable_delay: ready %b right after CC.EN, required 0", controller_ready); end
        wait_ready(cyc);
        checks++;
        if (controller_ready !== 1'b1 || active_queues !== 16'd1) begin
            errors++; $display("FAIL enable_ready: ready %b queues %0d after %0d cycles, required 1/1 within 20", controller_ready, active_queues, cyc);
        end
        reg_read(31'h1C, d, ok);
        checks++;
        if (!ok || d !== 64'h0000001C_00000001) begin errors++; $display("FAIL csts_read: got %h required 0000001C00000001", d); end
    endtask

    task automatic test_single_command();
        obs_t o;
        logic [63:0] cmd, ef, es, eca, ecd;
        reg_write(31'h24, 32'h000F_000F);
        reg_write(31'h28, 32'h1000); reg_write(31'h2C, 32'h0);
        reg_write(31'h30, 32'h2000); reg_write(31'h34, 32'h0);
        m_sq_size = 16; m_cq_size = 16; m_asq = 64'h1000; m_acq = 64'h2000;
        reg_write(31'h1000, 32'd1);
        m_tail = 1;
        cmd = {32'h5, 16'h7, 8'h0, 8'h01};
        run_cmd(cmd, 0, -1, o);
        model_cmd(cmd, 0, ef, es, eca, ecd);
        checks++;
        if (!o.ok || o.fetch_addr !== ef || o.fetch_size !== 8'd64 || o.fetch_wr !== 1'b0) begin
            errors++; $display("FAIL first_fetch: ok %b addr %h size %0d wr %b required 1 %h 64 0", o.ok, o.fetch_addr, o.fetch_size, o.fetch_wr, ef);
        end
        checks++;
        if (o.dma_src !== es || o.dma_len !== 32'd4096 || o.dma_wr !== 1'b1 || o.dma_dst !== 64'h0 || o.ack_drop !== 1'b1) begin
            errors++; $display("FAIL first_dma: src %h len %0d wr %b dst %h dropped %b required %h 4096 1 0 1",
                               o.dma_src, o.dma_len, o.dma_wr, o.dma_dst, o.ack_drop, es);
        end
        checks++;
        if (o.cq_addr !== eca || o.cq_data !== ecd || o.cq_size !== 8'd16 || o.cq_wr !== 1'b1) begin
            errors++; $display("FAIL first_cq: addr %h data %h size %0d wr %b required %h %h 16 1", o.cq_addr, o.cq_data, o.cq_size, o.cq_wr, eca, ecd);
        end
        checks++;
        if (o.msi_vec !== 16'h0) begin errors++; $display("FAIL first_msi: vector %h required 0", o.msi_vec); end
        checks++;
        if (commands_processed !== (STATS ? 32'(m_cmds) : 32'h0) || data_transferred !== (STATS ? 64'(m_bytes) : 64'h0)) begin
            errors++; $display("FAIL first_stats: cmds %0d bytes %0d required %0d %0d", commands_processed, data_transferred,
                               STATS ? m_cmds : 0, STATS ? m_bytes : 0);
        end
    endtask

    task automatic test_doorbell_limits();
        reg_write(31'h24, 32'h0FFF_0FFF);
        reg_write(31'h1000, 32'd1024);
        for (int k = 0; k < 6; k++) step();
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL clamp_doorbell: mem_req %b after doorbell 1024, required 0", mem_req); end
        reg_write(31'h24, 32'h000F_000F);
        reg_write(31'h1000, 32'd16);
        for (int k = 0; k < 6; k++) step();
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL size_doorbell: mem_req %b after doorbell 16, required 0", mem_req); end
    endtask

    task automatic test_wrap();
        obs_t o;
        logic [63:0] cmd, ef, es, eca, ecd;
        int db;
        for (int i = 0; i < 16; i++) begin
            db = -1;
            if (i != 6) begin
                m_tail = (m_tail + 1) % m_sq_size;
                reg_write(31'h1000, m_tail);
            end
            if (i == 5) db = int'((m_tail + 1) % m_sq_size);
            cmd = {$urandom, $urandom};
            run_cmd(cmd, 0, db, o);
            if (db >= 0) m_tail = db;
            model_cmd(cmd, 0, ef, es, eca, ecd);
            checks++;
            if (!o.ok || o.fetch_addr !== ef || o.dma_src !== es || o.dma_wr !== cmd[0]) begin
                errors++; $display("FAIL wrap_fetch_dma[%0d]: ok %b addr %h src %h wr %b required 1 %h %h %b",
                                   i, o.ok, o.fetch_addr, o.dma_src, o.dma_wr, ef, es, cmd[0]);
            end
            checks++;
            if (o.cq_addr !== eca || o.cq_data !== ecd) begin
                errors++; $display("FAIL wrap_cq[%0d]: addr %h data %h required %h %h", i, o.cq_addr, o.cq_data, eca, ecd);
            end
        end
        checks++;
        if (commands_processed !== (STATS ? 32'(m_cmds) : 32'h0) || data_transferred !== (STATS ? 64'(m_bytes) : 64'h0)) begin
            errors++; $display("FAIL wrap_stats: cmds %0d bytes %0d required %0d %0d", commands_processed, data_transferred,
                               STATS ? m_cmds : 0, STATS ? m_bytes : 0);
        end
    endtask

    task automatic test_errors();
        obs_t o;
        logic [63:0] cmd, ef, es, eca, ecd;
        logic [31:0] err0;
        err0 = error_count;
        dma_error = 1'b1;
        step();
        dma_error = 1'b0;
        m_errs++;
        checks++;
        if (error_count !== (STATS ? 32'(m_errs) : 32'h0)) begin
            errors++; $display("FAIL idle_error: count %0d required %0d (was %0d)", error_count, STATS ? m_errs : 0, err0);
        end
        for (int mode = 1; mode <= 2; mode++) begin
            m_tail = (m_tail + 1) % m_sq_size;
            reg_write(31'h1000, m_tail);
            cmd = {$urandom, $urandom};
            run_cmd(cmd, mode, -1, o);
            model_cmd(cmd, mode, ef, es, eca, ecd);
            checks++;
            if (!o.ok || o.cq_addr !== eca || o.cq_data !== ecd || o.msi_vec !== 16'h0) begin
                errors++; $display("FAIL error_completion[%0d]: ok %b addr %h data %h msi %h required 1 %h %h 0",
                                   mode, o.ok, o.cq_addr, o.cq_data, o.msi_vec, eca, ecd);
            end
            checks++;
            if (error_count !== (STATS ? 32'(m_errs) : 32'h0) || data_transferred !== (STATS ? 64'(m_bytes) : 64'h0) ||
                commands_processed !== (STATS ? 32'(m_cmds) : 32'h0)) begin
                errors++; $display("FAIL error_stats[%0d]: errs %0d bytes %0d cmds %0d required %0d %0d %0d", mode, error_count,
                                   data_transferred, commands_processed, STATS ? m_errs : 0, STATS ? m_bytes : 0, STATS ? m_cmds : 0);
            end
        end
    endtask

    task automatic test_disable_reenable();
        obs_t o;
        logic [63:0] cmd, ef, es, eca, ecd;
        int n = 0, cyc;
        m_tail = (m_tail + 1) % m_sq_size;
        reg_write(31'h1000, m_tail);
        while (!mem_req && n < 100) begin step(); n++; end
        mem_rdata = {$urandom, $urandom}; mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        n = 0;
        while (!dma_req && n < 100) begin step(); n++; end
        checks++;
        if (dma_req !== 1'b1) begin errors++; $display("FAIL disable_setup: dma_req %b required 1", dma_req); end
        reg_write(31'h14, 32'h0);
        step();
        checks++;
        if ({dma_req, mem_req, controller_ready, active_queues} !== 19'h0) begin
            errors++; $display("FAIL disable: dma_req %b mem_req %b ready %b queues %0d required 0 0 0 0",
                               dma_req, mem_req, controller_ready, active_queues);
        end
        m_head = 0; m_tail = 0; m_cq_tail = 0; m_phase = 1'b1;
        reg_write(31'h14, 32'h1);
        wait_ready(cyc);
        checks++;
        if (controller_ready !== 1'b1 || active_queues !== 16'd1) begin
            errors++; $display("FAIL reenable_ready: ready %b queues %0d required 1 1", controller_ready, active_queues);
        end
        m_tail = 1;
        reg_write(31'h1000, 32'd1);
        cmd = {$urandom, $urandom};
        run_cmd(cmd, 0, -1, o);
        model_cmd(cmd, 0, ef, es, eca, ecd);
        checks++;
        if (!o.ok || o.fetch_addr !== ef || o.dma_src !== es || o.cq_addr !== eca || o.cq_data !== ecd) begin
            errors++; $display("FAIL reenable_cmd: ok %b fetch %h src %h cq %h data %h required 1 %h %h %h %h",
                               o.ok, o.fetch_addr, o.dma_src, o.cq_addr, o.cq_data, ef, es, eca, ecd);
        end
        checks++;
        if (commands_processed !== (STATS ? 32'(m_cmds) : 32'h0)) begin
            errors++; $display("FAIL reenable_stats: cmds %0d required %0d", commands_processed, STATS ? m_cmds : 0);
        end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_enable();
        test_single_command();
        test_doorbell_limits();
        test_wrap();
        test_errors();
        test_disable_reenable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nvme_admin_ctrl.md
Name: nvme_admin_ctrl

Overview:
- Lightweight NVMe controller endpoint handling only the admin submission/completion queue pair.
- Accepts register writes and reads as 64-bit PCIe-side words.
- For each submitted command: fetches the command from host memory, runs one data DMA, writes a completion entry, then raises an MSI.
- Sits between the PCIe transaction layer and the SoC memory/DMA fabric; exports status and statistics.

Parameters:
- DATA_WIDTH, 64, memory data bus width (fixed 64).
- ADDR_WIDTH, 64, memory/DMA address width.
- MAX_QUEUES, 64, reported in CAP; only queue 0 is implemented.
- QUEUE_DEPTH, 1024, maximum admin queue entries; AQA sizes are clamped to this.
- MAX_NAMESPACES, 16, reported in register 0x38.

Ports:
- clk in 1: the single clock.
- rst in 1: reset. Synchronous and active-high.
- pcie_rx_data in 64: [63] read flag, [62:32] register address, [31:0] write data.
- pcie_rx_valid in 1 / pcie_rx_ready out 1: register request handshake.
- pcie_tx_data out 64: read response {address, data}.
- pcie_tx_valid out 1 / pcie_tx_ready in 1: response handshake.
- mem_req out 1: memory request.
- mem_addr out ADDR_WIDTH: memory request address.
- mem_wdata out 64: memory write data.
- mem_rdata in 64: memory read data.
- mem_write out 1: 1 = memory write.
- mem_size out 8: request size in bytes.
- mem_ready in 1: write accepted.
- mem_valid in 1: read data valid.
- dma_req out 1, dma_ack in 1: data-move request and acknowledge.
- dma_src_addr out ADDR_WIDTH, dma_dst_addr out ADDR_WIDTH: DMA source and destination.
- dma_length out 32: DMA length in bytes.
- dma_write out 1: 1 = host-to-device.
- dma_done in 1: DMA completed.
- dma_error in 1: DMA failed.
- msi_vector out 16, msi_valid out 1, msi_ready in 1: interrupt handshake.
- controller_ready out 1: CSTS.RDY.
- active_queues out 16: number of enabled queue pairs.
- commands_processed out 32, error_count out 32, data_transferred out 64: statistics.

Behaviour:
- Reset: all outputs 0, FSM in DISABLED, registers cleared. Exception: pcie_rx_ready is 1 whenever rst=0.
- Register transfer: a request is taken when pcie_rx_valid & pcie_rx_ready.
  - Writes take effect on the next edge.
  - Reads present {address, data} on pcie_tx one cycle later and hold it until pcie_tx_ready.
  - pcie_rx_ready is 0 while a response is pending.
- Register map (byte offsets):
  - 0x00 CAP: RO, {MAX_QUEUES-1, QUEUE_DEPTH-1}.
  - 0x08 VS: RO, 0x00010400.
  - 0x14 CC: bit0 EN.
  - 0x1C CSTS: bit0 RDY.
  - 0x24 AQA: [11:0] ASQ size-1, [27:16] ACQ size-1.
  - 0x28/0x2C ASQ base lo/hi.
  - 0x30/0x34 ACQ base lo/hi.
  - 0x38 namespace count: RO, MAX_NAMESPACES.
  - 0x1000 SQ0 tail doorbell.
  - Unmapped addresses read 0; writes to them are ignored.
- Enable sequence:
  - CC.EN 0→1 moves DISABLED→ENABLING.
  - After 16 cycles: controller_ready=1, active_queues=1, state READY.
  - CC.EN=0 in any state: next cycle returns to DISABLED, ready=0, active_queues=0, SQ head/tail and CQ tail cleared, outstanding req/valid outputs dropped.
- Command flow, from READY when sq_head != sq_tail:
  - FETCH: mem_req=1, mem_write=0, mem_size=64, mem_addr=ASQ base + head*64. Held until mem_valid.
  - Decode from mem_rdata: opcode [7:0], CID [31:16], PRP page [63:32].
  - DMA: dma_req=1 with length 4096, dma_write=opcode[0], src=PRP<<12, dst=0. dma_req drops on dma_ack, then the FSM waits for dma_done or dma_error.
  - CQ_WRITE: mem_req=1, mem_write=1, mem_size=16, mem_addr=ACQ base + cq_tail*16, mem_wdata={status[15:1], phase, CID, 16'h0, sq_head}. Held until mem_ready.
  - MSI: msi_valid=1, msi_vector=0, held until msi_ready. Then return to READY.
- Completion status: 0 on success; 0x0004 (data transfer error) when dma_error ended the DMA.
- Wrap: head and CQ tail wrap at the programmed size (clamped to QUEUE_DEPTH). The phase bit toggles on each CQ wrap. A doorbell value ≥ size is ignored.
- Statistics:
  - commands_processed +1 at each MSI handshake.
  - data_transferred += 4096 on dma_done.
  - error_count +1 on every dma_error cycle, in any state after reset, including idle.
  - Counters wrap.
- Simultaneous dma_done & dma_error: treated as an error, and no bytes are added.
- A doorbell write during processing updates the tail; new commands are picked up after the current one completes.

Optional Feature:
- NVME_STATS_EN:
  - Defined: the three statistics counters operate as specified.
  - Undefined: commands_processed, error_count and data_transferred are tied to 0 and the counter logic is removed; command flow is unchanged.

Test Plan:
- Reset, then read 0x08 → tx {0x8, 0x00010400}. After reset: controller_ready=0, active_queues=0.
- Write 0x14=1 → within 20 cycles controller_ready=1 and active_queues=1; CSTS read returns 1.
- Program AQA=0x000F000F, ASQ=0x1000, ACQ=0x2000, doorbell 0x1000=1; mem_valid with rdata={32'h5, 16'h7, 8'h0, 8'h01} → the following occur in order:
  - dma_req with src 0x5000, length 4096, dma_write=1.
  - After dma_done: CQ write at 0x2000 with CID 7.
  - MSI vector 0.
  - commands_processed=1, data_transferred=4096.
- Issue 16 commands across the wrap point → head wraps to 0; CQ phase bit flips in the entry written after the 16th completion.
- Pulse dma_error while idle, then once during a DMA → error_count=2; the completion carries status 0x0004; an MSI is still raised.
- Write 0x14=0 mid-DMA → next cycle dma_req=0, controller_ready=0, active_queues=0; re-enabling works normally.
